// File: rtl/alu32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu32_pkg
// Description : Shared opcode and width constants for the 32-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu32_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

endpackage : alu32_pkg
`default_nettype wire

// File: rtl/alu32_addsub.sv
`default_nettype none
// ============================================================================
// Module      : alu32_addsub
// Description : Combinational 32-bit adder/subtractor with carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module alu32_addsub
  import alu32_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic                 sub,
  output logic [ALU_WIDTH-1:0] sum,
  output logic                 cout
);

  logic [ALU_WIDTH-1:0] w_b_eff;
  logic [ALU_WIDTH:0]   w_full;

  // Subtraction is A + ~B + 1; carry out then means "no borrow".
  assign w_b_eff = sub ? ~b : b;
  assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{ALU_WIDTH{1'b0}}, sub};

  assign sum  = w_full[ALU_WIDTH-1:0];
  assign cout = w_full[ALU_WIDTH];

endmodule : alu32_addsub
`default_nettype wire

// File: rtl/alu32.sv
`default_nettype none
// ============================================================================
// Module      : alu32
// Description : Registered 32-bit ALU, eight operations, result + carry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu32
  import alu32_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [ALU_WIDTH-1:0] iA,
  input  logic [ALU_WIDTH-1:0] iB,
  input  logic [2:0]           ctrl,
  output logic [ALU_WIDTH-1:0] out,
  output logic                 oCarry
);

  logic [ALU_WIDTH-1:0] w_sum;
  logic                 w_cout;
  logic                 w_sub;
  logic                 w_slt;
  logic [ALU_WIDTH-1:0] w_result;
  logic                 w_carry;
  logic [ALU_WIDTH-1:0] r_out;
  logic                 r_carry;

  assign w_sub = (ctrl == ALU_SUB);

  alu32_addsub u_addsub (
    .a    (iA),
    .b    (iB),
    .sub  (w_sub),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // True signed compare, immune to the overflow that breaks sign-of-difference.
  assign w_slt = ($signed(iA) < $signed(iB));

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        w_result = w_sum;
        w_carry  = w_cout;
      end
      ALU_SUB: begin
        w_result = w_sum;
        w_carry  = w_cout;
      end
      ALU_AND: w_result = iA & iB;
      ALU_OR:  w_result = iA | iB;
      ALU_XOR: w_result = iA ^ iB;
      ALU_NOR: w_result = ~(iA | iB);
      ALU_SLT: w_result = {{(ALU_WIDTH-1){1'b0}}, w_slt};
      ALU_SLL: w_result = iA << iB[4:0];
      default: begin
        w_result = '0;
        w_carry  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_out   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_out   <= w_result;
      r_carry <= w_carry;
    end
  end

  assign out    = r_out;
  assign oCarry = r_carry;

endmodule : alu32
`default_nettype wire

// File: tb/tb_alu32.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu32
// Description : Self-checking bench for alu32 with directed and random tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] dut_out;
  logic        dut_carry;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu32 dut (
    .iClk   (clk),
    .iRst   (rst),
    .iA     (a),
    .iB     (b),
    .ctrl   (op),
    .out    (dut_out),
    .oCarry (dut_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {carry, result} derived directly from the operation definitions.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] code);
    logic [32:0] wide;
    case (code)
      3'd0: begin
        wide = {1'b0, x} + {1'b0, y};
        return wide;
      end
      3'd1: return {(x >= y), x - y};
      3'd2: return {1'b0, x & y};
      3'd3: return {1'b0, x | y};
      3'd4: return {1'b0, x ^ y};
      3'd5: return {1'b0, ~(x | y)};
      3'd6: return ($signed(x) < $signed(y)) ? 33'd1 : 33'd0;
      default: return {1'b0, x << y[4:0]};
    endcase
  endfunction

  task automatic step(input logic r, input logic [31:0] x, input logic [31:0] y,
                      input logic [2:0] code);
    rst = r;
    a   = x;
    b   = y;
    op  = code;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 32'd5, 32'd7, 3'd0);
    checks++;
    if (dut_out !== 32'd0 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%h carry=%b required out=0 carry=0", dut_out, dut_carry);
    end
  endtask

  task automatic test_add_basic;
    step(1'b0, 32'd1, 32'd1, 3'd0);
    checks++;
    if (dut_out !== 32'd2 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL add_1_1: out=%h carry=%b required out=2 carry=0", dut_out, dut_carry);
    end
    step(1'b0, 32'd1, 32'd0, 3'd0);
    checks++;
    if (dut_out !== 32'd1 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL add_1_0: out=%h carry=%b required out=1 carry=0", dut_out, dut_carry);
    end
  endtask

  task automatic test_wrap;
    step(1'b0, 32'hFFFF_FFFF, 32'd1, 3'd0);
    checks++;
    if (dut_out !== 32'd0 || dut_carry !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: out=%h carry=%b required out=0 carry=1", dut_out, dut_carry);
    end
    step(1'b0, 32'd0, 32'd1, 3'd1);
    checks++;
    if (dut_out !== 32'hFFFF_FFFF || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: out=%h carry=%b required out=ffffffff carry=0", dut_out, dut_carry);
    end
    step(1'b0, 32'd5, 32'd3, 3'd1);
    checks++;
    if (dut_out !== 32'd2 || dut_carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_5_3: out=%h carry=%b required out=2 carry=1", dut_out, dut_carry);
    end
  endtask

  task automatic test_logic;
    logic [31:0] exp [4] = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00, 32'h000F_000F};
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'(k + 2));
      checks++;
      if (dut_out !== exp[k] || dut_carry !== 1'b0) begin
        errors++;
        $display("FAIL logic_op%0d: out=%h carry=%b required out=%h carry=0",
                 k + 2, dut_out, dut_carry, exp[k]);
      end
    end
  endtask

  task automatic test_slt;
    step(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'd6);
    checks++;
    if (dut_out !== 32'd1 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL slt_neg_pos: out=%h carry=%b required out=1 carry=0", dut_out, dut_carry);
    end
    step(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 3'd6);
    checks++;
    if (dut_out !== 32'd0 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL slt_pos_neg: out=%h carry=%b required out=0 carry=0", dut_out, dut_carry);
    end
    step(1'b0, 32'd3, 32'd3, 3'd6);
    checks++;
    if (dut_out !== 32'd0 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL slt_equal: out=%h carry=%b required out=0 carry=0", dut_out, dut_carry);
    end
  endtask

  task automatic test_sll_and_reset_priority;
    step(1'b0, 32'd1, 32'hFFFF_FFFF, 3'd7);
    checks++;
    if (dut_out !== 32'h8000_0000 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL sll_31: out=%h carry=%b required out=80000000 carry=0", dut_out, dut_carry);
    end
    step(1'b0, 32'd1, 32'h20, 3'd7);
    checks++;
    if (dut_out !== 32'd1 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL sll_0: out=%h carry=%b required out=1 carry=0", dut_out, dut_carry);
    end
    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0);
    checks++;
    if (dut_out !== 32'd0 || dut_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: out=%h carry=%b required out=0 carry=0", dut_out, dut_carry);
    end
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0);
    checks++;
    if (dut_out !== 32'hFFFF_FFFE || dut_carry !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: out=%h carry=%b required out=fffffffe carry=1", dut_out, dut_carry);
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp0;
    logic [32:0] exp1;
    exp0 = model(32'd100, 32'd23, 3'd0);
    exp1 = model(32'd100, 32'd23, 3'd1);
    step(1'b0, 32'd100, 32'd23, 3'd0);
    // Inputs changing between edges must not disturb the registered value.
    a  = 32'hDEAD_BEEF;
    op = 3'd1;
    #2;
    checks++;
    if ({dut_carry, dut_out} !== exp0) begin
      errors++;
      $display("FAIL hold_between_edges: got %h required %h", {dut_carry, dut_out}, exp0);
    end
    step(1'b0, 32'd100, 32'd23, 3'd1);
    checks++;
    if ({dut_carry, dut_out} !== exp1) begin
      errors++;
      $display("FAIL latency_next_edge: got %h required %h", {dut_carry, dut_out}, exp1);
    end
  endtask

  task automatic test_random;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  code;
    logic [32:0] exp;
    for (int n = 0; n < 400; n++) begin
      x    = $urandom;
      y    = $urandom;
      code = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) x = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) y = x;
      if ($urandom_range(0, 9) == 0) y = 32'h8000_0000;
      exp = model(x, y, code);
      step(1'b0, x, y, code);
      checks++;
      if ({dut_carry, dut_out} !== exp) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h: got carry=%b out=%h required carry=%b out=%h",
                 code, x, y, dut_carry, dut_out, exp[32], exp[31:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    op  = '0;
    test_reset();
    test_add_basic();
    test_wrap();
    test_logic();
    test_slt();
    test_sll_and_reset_priority();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu32
`default_nettype wire
